// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST controller.
package ram_bist_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;
  localparam logic [DATA_W_DEF-1:0] SEED_DEF = 4'b0101;

  typedef enum logic [2:0] {
    IDLE,
    W_UP,
    R_UP,
    DRAIN1,
    W_DN,
    R_DN,
    DRAIN2,
    DONE
  } state_e;

  function automatic logic [31:0] pat(
    input logic [31:0] a,
    input logic [31:0] seed,
    input int          dw
  );
    logic [31:0] m;
    m = (32'd1 << dw) - 32'd1;
    return (a ^ seed) & m;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data compare pipeline with sticky error flag.
// Optional first-error capture under RAM_BIST_ERR_LOG_EN.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef RAM_BIST_ERR_LOG_EN
  ,
  parameter int ADDR_W = ADDR_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] exp_i,
`ifdef RAM_BIST_ERR_LOG_EN
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_data_o,
`endif
  output logic              err_nxt_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic              err_q;
  logic              miss;

  assign miss      = vld_q && (ram_dout_i != exp_q);
  assign err_nxt_o = clr_i ? 1'b0 : (err_q | miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= rd_i;
      exp_q <= exp_i;
      err_q <= err_nxt_o;
    end
  end

`ifdef RAM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] ea_q;
  logic [DATA_W-1:0] ed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      ea_q <= '0;
      ed_q <= '0;
    end else begin
      a_q <= addr_i;
      if (clr_i) begin
        ea_q <= '0;
        ed_q <= '0;
      end else if (miss && !err_q) begin
        ea_q <= a_q;
        ed_q <= ram_dout_i;
      end
    end
  end

  assign err_addr_o = ea_q;
  assign err_data_o = ed_q;
`endif

endmodule

// File: rtl/ram_bist_ctrl.sv
// Four-phase march BIST driver for a single-port sync RAM.
// Define RAM_BIST_ERR_LOG_EN to add err_addr/err_data outputs.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int              ADDR_W = ADDR_W_DEF,
  parameter int              DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SEED = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
`ifdef RAM_BIST_ERR_LOG_EN
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
`endif
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q, pass_d;
  logic [DATA_W-1:0] pat_w;
  logic [DATA_W-1:0] exp_w;
  logic              accept;
  logic              rd;
  logic              err_nxt;

  assign pat_w = DATA_W'(pat(32'(addr_q), 32'(SEED), DATA_W));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    ram_en  = 1'b0;
    ram_wr  = 1'b0;
    ram_di  = '0;
    rd      = 1'b0;
    exp_w   = pat_w;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          accept  = 1'b1;
          pass_d  = 1'b0;
          state_d = W_UP;
        end
      end
      W_UP: begin
        ram_en = 1'b1;
        ram_wr = 1'b1;
        ram_di = pat_w;
        if (addr_q == A_LAST) begin
          state_d = R_UP;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + A_ONE;
        end
      end
      R_UP: begin
        ram_en = 1'b1;
        rd     = 1'b1;
        if (addr_q == A_LAST) state_d = DRAIN1;
        else addr_d = addr_q + A_ONE;
      end
      DRAIN1: begin
        state_d = W_DN;
        addr_d  = A_LAST;
      end
      W_DN: begin
        ram_en = 1'b1;
        ram_wr = 1'b1;
        ram_di = ~pat_w;
        if (addr_q == '0) begin
          state_d = R_DN;
          addr_d  = A_LAST;
        end else begin
          addr_d = addr_q - A_ONE;
        end
      end
      R_DN: begin
        ram_en = 1'b1;
        rd     = 1'b1;
        exp_w  = ~pat_w;
        if (addr_q == '0) state_d = DRAIN2;
        else addr_d = addr_q - A_ONE;
      end
      DRAIN2: begin
        // last R_DN compare resolves this cycle
        state_d = DONE;
        pass_d  = ~err_nxt;
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign ram_addr = addr_q;

  ram_bist_cmp #(
    .DATA_W (DATA_W)
`ifdef RAM_BIST_ERR_LOG_EN
    ,
    .ADDR_W (ADDR_W)
`endif
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .rd_i       (rd),
    .exp_i      (exp_w),
`ifdef RAM_BIST_ERR_LOG_EN
    .addr_i     (addr_q),
    .err_addr_o (err_addr),
    .err_data_o (err_data),
`endif
    .err_nxt_o  (err_nxt),
    .ram_dout_i (ram_dout)
  );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a faultable RAM model.
// Exercises RAM_BIST_ERR_LOG_EN outputs when that macro is defined.
module tb_ram_bist_ctrl;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DEPTH = 32;
  localparam logic [3:0] SEED = 4'b0101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, ram_en, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_dout = '0;
`ifdef RAM_BIST_ERR_LOG_EN
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];

  int checks = 0;
  int errors = 0;
  int bcnt, dcnt, seq_bad;
  logic pass_done;
  logic [3:0] w5, w31;

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
`ifdef RAM_BIST_ERR_LOG_EN
    .err_addr (err_addr),
    .err_data (err_data),
`endif
    .ram_dout (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_di;
      else ram_dout <= (mem[ram_addr] & ~sa0[ram_addr]) | sa1[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pm(input int a);
    return 4'(a) ^ SEED;
  endfunction

  function automatic logic [3:0] rdf(input logic [3:0] v, input int a);
    return (v & ~sa0[a]) | sa1[a];
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  // expected outcome from march semantics: every word must read back
  // P then ~P; first miscompare is in read order (up, then down)
  task automatic model(output bit ok, output int fa, output logic [3:0] fd);
    ok = 1'b1;
    fa = 0;
    fd = '0;
    for (int a = 0; a < DEPTH; a++)
      if (ok && rdf(pm(a), a) !== pm(a)) begin
        ok = 1'b0; fa = a; fd = rdf(pm(a), a);
      end
    for (int a = DEPTH - 1; a >= 0; a--)
      if (ok && rdf(~pm(a), a) !== ~pm(a)) begin
        ok = 1'b0; fa = a; fd = rdf(~pm(a), a);
      end
  endtask

  task automatic op_check(input int k);
    logic e_en, e_wr;
    int e_a;
    logic [3:0] e_di;
    bit ca, cd;
    e_en = 1'b1; e_wr = 1'b0; e_a = 0; e_di = '0; ca = 1'b1; cd = 1'b0;
    if (k < 32) begin
      e_wr = 1'b1; e_a = k; e_di = pm(k); cd = 1'b1;
    end else if (k < 64) begin
      e_a = k - 32;
    end else if (k == 64) begin
      e_en = 1'b0; ca = 1'b0;
    end else if (k < 97) begin
      e_wr = 1'b1; e_a = 96 - k; e_di = ~pm(96 - k); cd = 1'b1;
    end else if (k < 129) begin
      e_a = 128 - k;
    end else begin
      e_en = 1'b0; ca = 1'b0;
    end
    if (ram_en !== e_en || ram_wr !== e_wr ||
        (ca && ram_addr !== 5'(e_a)) || (cd && ram_di !== e_di))
      seq_bad++;
    if (k < 32 && ram_addr == 5'd5) w5 = ram_di;
    if (k < 32 && ram_addr == 5'd31) w31 = ram_di;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic watch(input int restart_at, input int rst_at, input bit tail);
    bit fin;
    fin = 1'b0;
    bcnt = 0; dcnt = 0; seq_bad = 0; w5 = 'x; w31 = 'x;
    for (int c = 0; c < 400 && !fin; c++) begin
      start = 1'b0;
      if (busy) begin
        op_check(bcnt);
        bcnt++;
        if (bcnt == restart_at) start = 1'b1;
      end
      if (done) begin
        dcnt++;
        pass_done = pass;
        fin = 1'b1;
      end
      if (rst_at >= 0 && busy && bcnt == rst_at + 1) begin
        chk("rst_at_addr", ram_addr, 20);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_en", ram_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    if (tail)
      repeat (4) begin
        if (done) dcnt++;
        @(negedge clk);
      end
  endtask

  task automatic full_run(input string tag);
    bit ok;
    int fa;
    logic [3:0] fd;
    model(ok, fa, fd);
    pulse_start();
    watch(-1, -1, 1'b1);
    chk({tag, "_busy"}, bcnt, 130);
    chk({tag, "_done"}, dcnt, 1);
    chk({tag, "_seq"}, seq_bad, 0);
    chk({tag, "_pass"}, pass_done, ok);
`ifdef RAM_BIST_ERR_LOG_EN
    chk({tag, "_eaddr"}, err_addr, ok ? 0 : fa);
    chk({tag, "_edata"}, err_data, ok ? 0 : fd);
`endif
  endtask

  initial begin
    int a, b, kind;
    logic [3:0] m;
    clear_faults();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_pass0", pass, 0);
    chk("rst_ram_en0", ram_en, 0);
    chk("rst_ram_wr0", ram_wr, 0);
    chk("rst_addr0", ram_addr, 0);
    chk("rst_di0", ram_di, 0);
`ifdef RAM_BIST_ERR_LOG_EN
    chk("rst_eaddr0", err_addr, 0);
    chk("rst_edata0", err_data, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    pulse_start();
    watch(-1, -1, 1'b0);
    chk("r1_busy", bcnt, 130);
    chk("r1_seq", seq_bad, 0);
    chk("r1_di5", w5, 4'b0000);
    chk("r1_di31", w31, 4'b1010);
    chk("r1_pass", pass_done, 1);

    pulse_start();
    chk("b2b_pass_clr", pass, 0);
    watch(-1, -1, 1'b1);
    chk("b2b_busy", bcnt, 130);
    chk("b2b_done", dcnt, 1);
    chk("b2b_pass", pass_done, 1);

    pulse_start();
    watch(40, -1, 1'b1);
    chk("restart_busy", bcnt, 130);
    chk("restart_done", dcnt, 1);
    chk("restart_seq", seq_bad, 0);

    pulse_start();
    watch(-1, 76, 1'b0);
    @(negedge clk);
    full_run("after_rst");

    sa0[7] = 4'b0010;
    full_run("stuck7");
    chk("stuck7_pass_const", pass_done, 0);
`ifdef RAM_BIST_ERR_LOG_EN
    chk("stuck7_eaddr_const", err_addr, 7);
    chk("stuck7_edata_const", err_data, 0);
`endif
    clear_faults();

    sa0[31] = 4'b0010;
    full_run("stuck31");
    chk("stuck31_pass_const", pass_done, 0);
    clear_faults();

    for (int it = 0; it < 6; it++) begin
      clear_faults();
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 31);
      b = $urandom_range(0, 31);
      m = 4'($urandom_range(1, 15));
      if (kind == 1) sa0[a] = m;
      else if (kind == 2) sa1[a] = m;
      else if (kind == 3) begin
        sa1[a] = m;
        sa0[b] = ~m;
      end
      full_run($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
